// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the round-robin neuron scheduler.
// Optional feature macro: SPIKE_CNT_EN (per-requester spike counters in the top).
package neuron_sched_pkg;

    localparam int NIB_W       = 4;
    localparam int STATE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EVAL,
        RESP
    } sched_state_t;

    function automatic int wrap_idx(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first active request at or above ptr, with wrap-around.
// Purely combinational so the owning block can accept in the same cycle.
module rr_arbiter
    import neuron_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[IW'(wrap_idx(int'(ptr), k, N))]) begin
                any = 1'b1;
                gnt[IW'(wrap_idx(int'(ptr), k, N))] = 1'b1;
                idx = IW'(wrap_idx(int'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/neuron_rr_sched.sv
// Time-multiplexes one perceptron neuron between NUM_REQ requesters with per-requester contexts.
// Define SPIKE_CNT_EN to add saturating per-requester spike counters and the cnt_sel/cnt_val read port.
//
// state | meaning
// IDLE  | arbitrate; accept one request and latch its inputs
// LOAD  | push the granted context into the neuron
// EVAL  | neuron enabled for EVAL_CYCLES; write-back on the last cycle
// RESP  | hold the response until the consumer takes it
module neuron_rr_sched
    import neuron_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int EVAL_CYCLES = 1,
    parameter int STATE_W     = STATE_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NIB_W*NUM_REQ-1:0]     req_v1,
    input  logic [NIB_W*NUM_REQ-1:0]     req_v2,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [STATE_W-1:0]           rsp_state,
    output logic                         rsp_spike,
    input  logic                         ctx_clr,
    output logic [NIB_W-1:0]             nrn_v_in1,
    output logic [NIB_W-1:0]             nrn_v_in2,
    output logic                         nrn_load,
    output logic [STATE_W-1:0]           nrn_state_in,
    output logic                         nrn_en,
    input  logic [STATE_W-1:0]           nrn_state_out,
    input  logic                         nrn_spike
`ifdef SPIKE_CNT_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0]   cnt_sel,
    output logic [7:0]                   cnt_val
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    sched_state_t       state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     cur_id;
    logic [IDW-1:0]     gidx;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [3:0]         eval_cnt;
    logic               clr_pend;
    logic               clr_now;
    logic               wb_now;
    logic [STATE_W-1:0] ctx [NUM_REQ];

    rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gnt_any)
    );

    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign wb_now    = (state == EVAL) && (eval_cnt == '0);
    // A clear seen while busy is deferred until the response leaves, so the write-back is also wiped.
    assign clr_now   = ((state == IDLE) && ctx_clr) ||
                       ((state == RESP) && rsp_ready && (ctx_clr || clr_pend));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) ctx[i] <= '0;
        end else if (clr_now) begin
            for (int i = 0; i < NUM_REQ; i++) ctx[i] <= '0;
        end else if (wb_now) begin
            ctx[cur_id] <= nrn_state_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            eval_cnt     <= '0;
            clr_pend     <= 1'b0;
            nrn_v_in1    <= '0;
            nrn_v_in2    <= '0;
            nrn_load     <= 1'b0;
            nrn_state_in <= '0;
            nrn_en       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_state    <= '0;
            rsp_spike    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cur_id       <= gidx;
                        rr_ptr       <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                        nrn_v_in1    <= req_v1[gidx*NIB_W +: NIB_W];
                        nrn_v_in2    <= req_v2[gidx*NIB_W +: NIB_W];
                        nrn_load     <= 1'b1;
                        nrn_state_in <= ctx_clr ? '0 : ctx[gidx];
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    nrn_load     <= 1'b0;
                    nrn_state_in <= '0;
                    nrn_en       <= 1'b1;
                    eval_cnt     <= 4'(EVAL_CYCLES - 1);
                    clr_pend     <= clr_pend | ctx_clr;
                    state        <= EVAL;
                end
                EVAL: begin
                    clr_pend <= clr_pend | ctx_clr;
                    if (eval_cnt == '0) begin
                        nrn_en    <= 1'b0;
                        nrn_v_in1 <= '0;
                        nrn_v_in2 <= '0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_state <= nrn_state_out;
                        rsp_spike <= nrn_spike;
                        state     <= RESP;
                    end else begin
                        eval_cnt <= eval_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        clr_pend  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        clr_pend  <= clr_pend | ctx_clr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_CNT_EN
    logic [7:0] spk_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) spk_cnt[i] <= '0;
        end else if (clr_now) begin
            for (int i = 0; i < NUM_REQ; i++) spk_cnt[i] <= '0;
        end else if (wb_now && nrn_spike && spk_cnt[cur_id] != 8'hFF) begin
            spk_cnt[cur_id] <= spk_cnt[cur_id] + 1'b1;
        end
    end

    assign cnt_val = spk_cnt[cnt_sel];
`endif

endmodule
